// File: rtl/bcd_display_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_display_feeder
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3, one bit
//             per clock) between the 8-bit output port and the 7-segment
//             display driver. A conversion starts when bin_i differs from the
//             last accepted value, or when force_i is pulsed in IDLE. Results
//             are registered, so the display never shows a partial value.
//  Ports    : clk        - system clock
//             reset      - asynchronous, active-high reset
//             bin_i      - binary value from the output port
//             force_i    - one-cycle reconvert request (honoured in IDLE only)
//             bcd_o      - registered BCD digits, digit 0 in [3:0]
//             digit_en_o - leading-zero blanking mask, bit 0 always set
//             sign_o     - negative flag (signed build only, else 0)
//             busy_o     - high while a conversion is in progress
//             done_o     - one-cycle pulse on the cycle bcd_o updates
//  Macro    : BCD_SIGNED_EN - treat bin_i as two's complement, convert the
//             magnitude and report the sign on sign_o.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_display_feeder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    bin_i,
  input  logic                force_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]   digit_en_o,
  output logic                sign_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int SCR_W = 4 * DIGITS;          // BCD scratch bits
  localparam int SR_W  = WIDTH + SCR_W;       // full shift register
  localparam int CNT_W = $clog2(WIDTH + 1);   // holds WIDTH down to 0

  // 10^n as a 64-bit constant, used only for the parameter range check.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] DEC_RANGE = pow10(DIGITS);
  localparam logic [63:0] BIN_RANGE = 64'd1 << WIDTH;

  // The scratch field must hold every input value, which is what lets the
  // datapath omit any overflow handling.
  generate
    if (DEC_RANGE <= BIN_RANGE) begin : g_param_check
      $error("bcd_display_feeder: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   last_bin;
  logic [SR_W-1:0]    sreg;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   magnitude;
  logic [SR_W-1:0]    adjusted;
  logic [DIGITS-1:0]  en_next;
  logic               any_nz;
  logic               unused_top;

  // --------------------------------------------------------------------------
  // Magnitude of the input at capture time.
  // --------------------------------------------------------------------------
`ifdef BCD_SIGNED_EN
  logic sign_cap;

  // Negating the most-negative value wraps back to itself, which read as
  // unsigned is exactly 2^(WIDTH-1) - the correct magnitude.
  assign magnitude = bin_i[WIDTH-1] ? ({WIDTH{1'b0}} - bin_i) : bin_i;
`else
  assign magnitude = bin_i;
  assign sign_o    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Add-3 correction on every scratch digit that is 5 or more, applied
  // before the shift so the digit carries correctly into the next one.
  // --------------------------------------------------------------------------
  always_comb begin
    adjusted = sreg;
    for (int d = 0; d < DIGITS; d++) begin
      if (sreg[WIDTH + 4*d +: 4] >= 4'd5)
        adjusted[WIDTH + 4*d +: 4] = sreg[WIDTH + 4*d +: 4] + 4'd3;
    end
  end

  // The top bit is shifted out each cycle; it is always zero because the
  // scratch field is wide enough for any input.
  assign unused_top = adjusted[SR_W-1];

  // --------------------------------------------------------------------------
  // Leading-zero blanking: digit k is shown if it or any higher digit is
  // nonzero. The units digit is always shown so zero displays as "0".
  // --------------------------------------------------------------------------
  always_comb begin
    en_next = '0;
    any_nz  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz     = any_nz | (sreg[WIDTH + 4*k +: 4] != 4'd0);
      en_next[k] = any_nz;
    end
    en_next[0] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Control FSM and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_bin   <= '0;
      sreg       <= '0;
      count      <= '0;
      bcd_o      <= '0;
      digit_en_o <= {{(DIGITS-1){1'b0}}, 1'b1};
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_cap   <= 1'b0;
      sign_o     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          // A change and a force in the same cycle start one conversion.
          if ((bin_i != last_bin) || force_i) begin
            sreg     <= {{SCR_W{1'b0}}, magnitude};
            last_bin <= bin_i;
            count    <= CNT_W'(WIDTH);
            busy_o   <= 1'b1;
`ifdef BCD_SIGNED_EN
            sign_cap <= bin_i[WIDTH-1];
`endif
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          sreg  <= {adjusted[SR_W-2:0], 1'b0};
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1))
            state <= DONE;
        end

        DONE: begin
          // All result outputs move together, in the same cycle as done_o.
          bcd_o      <= sreg[WIDTH +: SCR_W];
          digit_en_o <= en_next;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
`ifdef BCD_SIGNED_EN
          sign_o     <= sign_cap;
`endif
          state      <= IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_display_feeder
//  Purpose  : Directed self-checking bench for bcd_display_feeder with the
//             default WIDTH=8 / DIGITS=3 configuration. Inputs change on the
//             falling edge; outputs are sampled on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  bin_i;
  logic        force_i;
  logic [11:0] bcd_o;
  logic [2:0]  digit_en_o;
  logic        sign_o;
  logic        busy_o;
  logic        done_o;

  int nvec  = 0;
  int nfail = 0;

  // Hand-computed results that depend on the signedness of the build.
`ifdef BCD_SIGNED_EN
  localparam logic [11:0] EXP_255_BCD = 12'h001;   // 8'hFF = -1
  localparam logic [2:0]  EXP_255_EN  = 3'b001;
  localparam logic        EXP_255_SGN = 1'b1;
  localparam logic [11:0] EXP_200_BCD = 12'h056;   // 8'hC8 = -56
  localparam logic [2:0]  EXP_200_EN  = 3'b011;
  localparam logic        EXP_200_SGN = 1'b1;
`else
  localparam logic [11:0] EXP_255_BCD = 12'h255;
  localparam logic [2:0]  EXP_255_EN  = 3'b111;
  localparam logic        EXP_255_SGN = 1'b0;
  localparam logic [11:0] EXP_200_BCD = 12'h200;
  localparam logic [2:0]  EXP_200_EN  = 3'b111;
  localparam logic        EXP_200_SGN = 1'b0;
`endif

  bcd_display_feeder #(.WIDTH(8), .DIGITS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .bin_i      (bin_i),
    .force_i    (force_i),
    .bcd_o      (bcd_o),
    .digit_en_o (digit_en_o),
    .sign_o     (sign_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int dones;
    dones   = 0;
    reset   = 1'b1;
    bin_i   = 8'd0;
    force_i = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    nvec++; if (bcd_o !== 12'h000) begin nfail++; $display("FAIL reset_bcd got=%h exp=%h", bcd_o, 12'h000); end
    nvec++; if (digit_en_o !== 3'b001) begin nfail++; $display("FAIL reset_en got=%b exp=%b", digit_en_o, 3'b001); end
    nvec++; if (sign_o !== 1'b0) begin nfail++; $display("FAIL reset_sign got=%b exp=0", sign_o); end
    nvec++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    nvec++; if (done_o !== 1'b0) begin nfail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) dones++;
    end
    nvec++; if (dones != 0) begin nfail++; $display("FAIL zero_hold_activity got=%0d exp=0", dones); end
    nvec++; if (bcd_o !== 12'h000) begin nfail++; $display("FAIL zero_hold_bcd got=%h exp=%h", bcd_o, 12'h000); end
    nvec++; if (digit_en_o !== 3'b001) begin nfail++; $display("FAIL zero_hold_en got=%b exp=%b", digit_en_o, 3'b001); end
  endtask

  task automatic test_max;
    int busy_cnt, done_cnt, done_at;
    logic stable;
    logic [11:0] prev;
    busy_cnt = 0; done_cnt = 0; done_at = -1; stable = 1'b1; prev = bcd_o;
    bin_i = 8'd255;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cnt++; done_at = i; end
      else if (bcd_o !== prev) stable = 1'b0;
      prev = bcd_o;
    end
    nvec++; if (busy_cnt != 9) begin nfail++; $display("FAIL max_busy_cycles got=%0d exp=9", busy_cnt); end
    nvec++; if (done_at != 10) begin nfail++; $display("FAIL max_done_edge got=%0d exp=10", done_at); end
    nvec++; if (done_cnt != 1) begin nfail++; $display("FAIL max_done_count got=%0d exp=1", done_cnt); end
    nvec++; if (stable !== 1'b1) begin nfail++; $display("FAIL max_bcd_stable got=%b exp=1", stable); end
    nvec++; if (bcd_o !== EXP_255_BCD) begin nfail++; $display("FAIL max_bcd got=%h exp=%h", bcd_o, EXP_255_BCD); end
    nvec++; if (digit_en_o !== EXP_255_EN) begin nfail++; $display("FAIL max_en got=%b exp=%b", digit_en_o, EXP_255_EN); end
    nvec++; if (sign_o !== EXP_255_SGN) begin nfail++; $display("FAIL max_sign got=%b exp=%b", sign_o, EXP_255_SGN); end
  endtask

  task automatic test_force;
    int done_cnt, done_at;
    // Plain change to 7.
    bin_i = 8'd7;
    done_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done_o) done_cnt++;
    end
    nvec++; if (done_cnt != 1) begin nfail++; $display("FAIL seven_done_count got=%0d exp=1", done_cnt); end
    nvec++; if (bcd_o !== 12'h007) begin nfail++; $display("FAIL seven_bcd got=%h exp=%h", bcd_o, 12'h007); end
    nvec++; if (digit_en_o !== 3'b001) begin nfail++; $display("FAIL seven_en got=%b exp=%b", digit_en_o, 3'b001); end
    // Force in IDLE with unchanged input.
    done_cnt = 0; done_at = -1;
    for (int i = 1; i <= 24; i++) begin
      force_i = (i == 1);
      tick();
      force_i = 1'b0;
      if (done_o) begin done_cnt++; done_at = i; end
    end
    nvec++; if (done_cnt != 1) begin nfail++; $display("FAIL force_done_count got=%0d exp=1", done_cnt); end
    nvec++; if (done_at != 10) begin nfail++; $display("FAIL force_done_edge got=%0d exp=10", done_at); end
    nvec++; if (bcd_o !== 12'h007) begin nfail++; $display("FAIL force_bcd got=%h exp=%h", bcd_o, 12'h007); end
    nvec++; if (digit_en_o !== 3'b001) begin nfail++; $display("FAIL force_en got=%b exp=%b", digit_en_o, 3'b001); end
    // Second force lands during SHIFT and must be dropped.
    done_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      force_i = (i == 1) || (i == 4);
      tick();
      force_i = 1'b0;
      if (done_o) done_cnt++;
    end
    nvec++; if (done_cnt != 1) begin nfail++; $display("FAIL force_in_shift_count got=%0d exp=1", done_cnt); end
    // Change and force together: one conversion.
    done_cnt = 0;
    bin_i = 8'd8;
    for (int i = 1; i <= 24; i++) begin
      force_i = (i == 1);
      tick();
      force_i = 1'b0;
      if (done_o) done_cnt++;
    end
    nvec++; if (done_cnt != 1) begin nfail++; $display("FAIL change_and_force_count got=%0d exp=1", done_cnt); end
    nvec++; if (bcd_o !== 12'h008) begin nfail++; $display("FAIL change_and_force_bcd got=%h exp=%h", bcd_o, 12'h008); end
  endtask

  task automatic test_back_to_back;
    int done_cnt;
    int done_at [2];
    logic [11:0] res_bcd [2];
    logic [2:0]  res_en  [2];
    logic        res_sgn [2];
    done_cnt = 0;
    done_at[0] = -1; done_at[1] = -1;
    res_bcd[0] = 'x; res_bcd[1] = 'x;
    res_en[0] = 'x; res_en[1] = 'x;
    res_sgn[0] = 'x; res_sgn[1] = 'x;
    bin_i = 8'd200;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 3) bin_i = 8'd17;
      if (i == 5) bin_i = 8'd45;
      if (done_o) begin
        if (done_cnt < 2) begin
          done_at[done_cnt] = i;
          res_bcd[done_cnt] = bcd_o;
          res_en[done_cnt]  = digit_en_o;
          res_sgn[done_cnt] = sign_o;
        end
        done_cnt++;
      end
    end
    nvec++; if (done_cnt != 2) begin nfail++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    nvec++; if (res_bcd[0] !== EXP_200_BCD) begin nfail++; $display("FAIL b2b_first_bcd got=%h exp=%h", res_bcd[0], EXP_200_BCD); end
    nvec++; if (res_en[0] !== EXP_200_EN) begin nfail++; $display("FAIL b2b_first_en got=%b exp=%b", res_en[0], EXP_200_EN); end
    nvec++; if (res_sgn[0] !== EXP_200_SGN) begin nfail++; $display("FAIL b2b_first_sign got=%b exp=%b", res_sgn[0], EXP_200_SGN); end
    nvec++; if (res_bcd[1] !== 12'h045) begin nfail++; $display("FAIL b2b_second_bcd got=%h exp=%h", res_bcd[1], 12'h045); end
    nvec++; if (res_en[1] !== 3'b011) begin nfail++; $display("FAIL b2b_second_en got=%b exp=%b", res_en[1], 3'b011); end
    nvec++; if (done_at[1] - done_at[0] != 10) begin nfail++; $display("FAIL b2b_period got=%0d exp=10", done_at[1] - done_at[0]); end
  endtask

  task automatic test_reset_mid;
    int done_cnt, done_at;
    bin_i = 8'd99;
    repeat (4) tick();
    nvec++; if (busy_o !== 1'b1) begin nfail++; $display("FAIL mid_busy_before got=%b exp=1", busy_o); end
    reset = 1'b1;
    #1;
    nvec++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL mid_reset_busy got=%b exp=0", busy_o); end
    nvec++; if (bcd_o !== 12'h000) begin nfail++; $display("FAIL mid_reset_bcd got=%h exp=%h", bcd_o, 12'h000); end
    nvec++; if (digit_en_o !== 3'b001) begin nfail++; $display("FAIL mid_reset_en got=%b exp=%b", digit_en_o, 3'b001); end
    repeat (2) tick();
    nvec++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin nfail++; $display("FAIL mid_reset_hold got=%b%b exp=00", done_o, busy_o); end
    reset = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done_o) begin done_cnt++; done_at = i; end
    end
    nvec++; if (done_at != 10 || done_cnt != 1) begin nfail++; $display("FAIL mid_reconvert_edge got=%0d/%0d exp=10/1", done_at, done_cnt); end
    nvec++; if (bcd_o !== 12'h099) begin nfail++; $display("FAIL mid_reconvert_bcd got=%h exp=%h", bcd_o, 12'h099); end
    nvec++; if (digit_en_o !== 3'b011) begin nfail++; $display("FAIL mid_reconvert_en got=%b exp=%b", digit_en_o, 3'b011); end
  endtask

`ifdef BCD_SIGNED_EN
  task automatic test_signed;
    logic [7:0]  vin  [3] = '{8'hFF, 8'h80, 8'h7F};
    logic [11:0] vbcd [3] = '{12'h001, 12'h128, 12'h127};
    logic [2:0]  ven  [3] = '{3'b001, 3'b111, 3'b111};
    logic        vsgn [3] = '{1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      bin_i = vin[v];
      repeat (12) tick();
      nvec++; if (bcd_o !== vbcd[v]) begin nfail++; $display("FAIL signed_bcd_%0d got=%h exp=%h", v, bcd_o, vbcd[v]); end
      nvec++; if (digit_en_o !== ven[v]) begin nfail++; $display("FAIL signed_en_%0d got=%b exp=%b", v, digit_en_o, ven[v]); end
      nvec++; if (sign_o !== vsgn[v]) begin nfail++; $display("FAIL signed_sign_%0d got=%b exp=%b", v, sign_o, vsgn[v]); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_max();
    test_force();
    test_back_to_back();
    test_reset_mid();
`ifdef BCD_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
